// File: rtl/bus_xfer_pkg.sv
// Shared types and helpers for the bus transfer sequencer: FSM states,
// the queued request record and the index-to-one-hot decoder.
package bus_xfer_pkg;

    localparam int MAX_REGS  = 64;
    localparam int MAX_IDX_W = 6;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        LATCH = 2'd2,
        GAP   = 2'd3
    } xfer_state_t;

    typedef struct packed {
        logic [MAX_IDX_W-1:0] src;
        logic [MAX_IDX_W-1:0] dst;
    } xfer_req_t;

    // Out-of-range indices decode to all zeros so a bad index can never open a tristate.
    function automatic logic [MAX_REGS-1:0] onehot(
        input logic [MAX_IDX_W-1:0] idx,
        input logic [MAX_IDX_W:0]   num_regs
    );
        onehot = '0;
        if ({1'b0, idx} < num_regs) begin
            onehot[idx] = 1'b1;
        end
    endfunction

endpackage

// File: rtl/bus_xfer_sequencer_if.sv
// Request/enable bundle between a transfer requester (master) and the
// sequencer that drives the shared datapath bus (slave).
interface bus_xfer_sequencer_if #(
    parameter int NUM_REGS = 16
);
    localparam int IDX_W = $clog2(NUM_REGS);

    logic                flush;
    logic                req_valid;
    logic                req_ready;
    logic [IDX_W-1:0]    req_src;
    logic [IDX_W-1:0]    req_dst;
    logic [NUM_REGS-1:0] rout;
    logic [NUM_REGS-1:0] ren;
    logic                busy;
    logic                done;
    logic                err;

    modport master (
        output flush, req_valid, req_src, req_dst,
        input  req_ready, rout, ren, busy, done, err
    );

    modport slave (
        input  flush, req_valid, req_src, req_dst,
        output req_ready, rout, ren, busy, done, err
    );

endinterface

// File: rtl/xfer_req_fifo.sv
// Small synchronous request queue with flush; pointers carry one extra
// wrap bit so full and empty come straight from a pointer compare.
module xfer_req_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= wdata;
        end
    end

    assign rdata = mem[rd_ptr[AW-1:0]];
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/bus_xfer_sequencer.sv
// Queues register-to-register transfers and plays each one onto the shared
// bus as registered one-hot enables: source open, destination load, then a quiet gap.
module bus_xfer_sequencer
    import bus_xfer_pkg::*;
#(
    parameter int NUM_REGS   = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int GAP_CYCLES = 1
) (
    input  logic                 clk,
    input  logic                 resetn,
    bus_xfer_sequencer_if.slave  bus
);
    localparam int                   IDX_W    = $clog2(NUM_REGS);
    localparam logic [MAX_IDX_W:0]   NREGS    = NUM_REGS[MAX_IDX_W:0];
    localparam logic [1:0]           GAP_LOAD = 2'(GAP_CYCLES - 1);

    xfer_state_t          state;
    logic [1:0]           gap_cnt;
    logic [MAX_IDX_W-1:0] cur_dst;
    logic [NUM_REGS-1:0]  rout_q;
    logic [NUM_REGS-1:0]  ren_q;
    logic                 done_q;
    logic                 err_q;

    logic                 fifo_push;
    logic                 fifo_pop;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [2*IDX_W-1:0]   fifo_wdata;
    logic [2*IDX_W-1:0]   fifo_rdata;
    xfer_req_t            head_req;
    logic                 head_ok;

    assign fifo_wdata = {bus.req_src, bus.req_dst};
    assign fifo_push  = bus.req_valid && !fifo_full && !bus.flush;
    assign fifo_pop   = (state == IDLE) && !fifo_empty && !bus.flush;

    xfer_req_fifo #(
        .WIDTH (2*IDX_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .resetn (resetn),
        .flush  (bus.flush),
        .push   (fifo_push),
        .pop    (fifo_pop),
        .wdata  (fifo_wdata),
        .rdata  (fifo_rdata),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    // Indices are IDX_W wide, so a non power-of-two register count leaves encodings that must be rejected.
    always_comb begin
        head_req.src = MAX_IDX_W'(fifo_rdata[2*IDX_W-1:IDX_W]);
        head_req.dst = MAX_IDX_W'(fifo_rdata[IDX_W-1:0]);
        head_ok      = ({1'b0, head_req.src} < NREGS) && ({1'b0, head_req.dst} < NREGS);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state   <= IDLE;
            gap_cnt <= '0;
            cur_dst <= '0;
            rout_q  <= '0;
            ren_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            if (bus.flush) begin
                state   <= IDLE;
                gap_cnt <= '0;
                rout_q  <= '0;
                ren_q   <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (!fifo_empty) begin
                            if (head_ok) begin
                                state   <= DRIVE;
                                cur_dst <= head_req.dst;
                                rout_q  <= NUM_REGS'(onehot(head_req.src, NREGS));
                            end else begin
                                err_q <= 1'b1;
                            end
                        end
                    end
                    DRIVE: begin
                        state  <= LATCH;
                        ren_q  <= NUM_REGS'(onehot(cur_dst, NREGS));
                        done_q <= 1'b1;
                    end
                    LATCH: begin
                        rout_q <= '0;
                        ren_q  <= '0;
                        if (GAP_CYCLES == 0) begin
                            state <= IDLE;
                        end else begin
                            state   <= GAP;
                            gap_cnt <= GAP_LOAD;
                        end
                    end
                    GAP: begin
                        if (gap_cnt == 2'd0) begin
                            state <= IDLE;
                        end else begin
                            gap_cnt <= gap_cnt - 1'b1;
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.rout      = rout_q;
    assign bus.ren       = ren_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
    assign bus.busy      = (state != IDLE) || !fifo_empty;
    assign bus.req_ready = !fifo_full;

endmodule

// File: tb/tb_bus_xfer_sequencer.sv
// Drives three sequencer configurations with the same request stream and
// compares each cycle against a queue-based transfer model.
module tb_bus_xfer_sequencer;

    localparam int NDUT  = 3;
    localparam int DEPTH = 4;

    logic       clk    = 1'b0;
    logic       resetn = 1'b1;
    logic       flush  = 1'b0;
    logic       req_valid = 1'b0;
    logic [3:0] req_src = '0;
    logic [3:0] req_dst = '0;

    always #5 clk = ~clk;

    bus_xfer_sequencer_if #(.NUM_REGS(16)) ifa ();
    bus_xfer_sequencer_if #(.NUM_REGS(12)) ifb ();
    bus_xfer_sequencer_if #(.NUM_REGS(16)) ifc ();

    assign ifa.flush = flush;  assign ifa.req_valid = req_valid;
    assign ifa.req_src = req_src;  assign ifa.req_dst = req_dst;
    assign ifb.flush = flush;  assign ifb.req_valid = req_valid;
    assign ifb.req_src = req_src;  assign ifb.req_dst = req_dst;
    assign ifc.flush = flush;  assign ifc.req_valid = req_valid;
    assign ifc.req_src = req_src;  assign ifc.req_dst = req_dst;

    bus_xfer_sequencer #(.NUM_REGS(16), .FIFO_DEPTH(DEPTH), .GAP_CYCLES(1)) dut_a (
        .clk (clk), .resetn (resetn), .bus (ifa)
    );
    bus_xfer_sequencer #(.NUM_REGS(12), .FIFO_DEPTH(DEPTH), .GAP_CYCLES(0)) dut_b (
        .clk (clk), .resetn (resetn), .bus (ifb)
    );
    bus_xfer_sequencer #(.NUM_REGS(16), .FIFO_DEPTH(DEPTH), .GAP_CYCLES(3)) dut_c (
        .clk (clk), .resetn (resetn), .bus (ifc)
    );

    logic [63:0] obs_rout [NDUT];
    logic [63:0] obs_ren  [NDUT];
    logic        obs_done [NDUT];
    logic        obs_err  [NDUT];
    logic        obs_busy [NDUT];
    logic        obs_ready[NDUT];

    assign obs_rout[0] = 64'(ifa.rout);  assign obs_ren[0] = 64'(ifa.ren);
    assign obs_rout[1] = 64'(ifb.rout);  assign obs_ren[1] = 64'(ifb.ren);
    assign obs_rout[2] = 64'(ifc.rout);  assign obs_ren[2] = 64'(ifc.ren);
    assign obs_done[0] = ifa.done;  assign obs_err[0] = ifa.err;
    assign obs_done[1] = ifb.done;  assign obs_err[1] = ifb.err;
    assign obs_done[2] = ifc.done;  assign obs_err[2] = ifc.err;
    assign obs_busy[0] = ifa.busy;  assign obs_ready[0] = ifa.req_ready;
    assign obs_busy[1] = ifb.busy;  assign obs_ready[1] = ifb.req_ready;
    assign obs_busy[2] = ifc.busy;  assign obs_ready[2] = ifc.req_ready;

    typedef struct {
        logic [63:0] rout;
        logic [63:0] ren;
        bit          done;
        bit          err;
    } cyc_t;

    int   nregs [NDUT] = '{16, 12, 16};
    int   gaps  [NDUT] = '{1, 0, 3};
    cyc_t plan  [NDUT][$];
    int   rq    [NDUT][$];
    cyc_t cur   [NDUT];
    bit   cur_idle [NDUT];

    int checks = 0;
    int errors = 0;
    int cycle  = 0;

    function automatic logic [63:0] oh(input int i, input int n);
        return (i >= 0 && i < n) ? (64'd1 << i) : 64'd0;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < NDUT; d++) begin
            plan[d].delete();
            rq[d].delete();
            cur[d]      = '{64'd0, 64'd0, 1'b0, 1'b0};
            cur_idle[d] = 1'b1;
        end
    endtask

    // Each accepted request expands into its full output sequence once popped from an idle sequencer.
    task automatic model_update();
        for (int d = 0; d < NDUT; d++) begin
            bit   ready;
            cyc_t nxt;
            int   h;
            int   s;
            int   t;
            ready = (rq[d].size() < DEPTH);
            nxt   = '{64'd0, 64'd0, 1'b0, 1'b0};
            if (flush) begin
                plan[d].delete();
                rq[d].delete();
                cur[d]      = nxt;
                cur_idle[d] = 1'b1;
                continue;
            end
            if (plan[d].size() > 0) begin
                nxt         = plan[d].pop_front();
                cur_idle[d] = 1'b0;
            end else if (!cur_idle[d]) begin
                cur_idle[d] = 1'b1;
            end else if (rq[d].size() > 0) begin
                h = rq[d].pop_front();
                s = h / 16;
                t = h % 16;
                if (s < nregs[d] && t < nregs[d]) begin
                    nxt.rout = oh(s, nregs[d]);
                    plan[d].push_back('{oh(s, nregs[d]), oh(t, nregs[d]), 1'b1, 1'b0});
                    for (int g = 0; g < gaps[d]; g++) begin
                        plan[d].push_back('{64'd0, 64'd0, 1'b0, 1'b0});
                    end
                    cur_idle[d] = 1'b0;
                end else begin
                    nxt.err = 1'b1;
                end
            end
            if (req_valid && ready) begin
                rq[d].push_back(int'(req_src) * 16 + int'(req_dst));
            end
            cur[d] = nxt;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cycle, observed, expected);
        end
    endtask

    task automatic check_all();
        for (int d = 0; d < NDUT; d++) begin
            checkOutput($sformatf("rout[%0d]", d), obs_rout[d], cur[d].rout);
            checkOutput($sformatf("ren[%0d]", d), obs_ren[d], cur[d].ren);
            checkOutput($sformatf("done[%0d]", d), 64'(obs_done[d]), 64'(cur[d].done));
            checkOutput($sformatf("err[%0d]", d), 64'(obs_err[d]), 64'(cur[d].err));
            checkOutput($sformatf("busy[%0d]", d), 64'(obs_busy[d]),
                        64'(!cur_idle[d] || rq[d].size() > 0));
            checkOutput($sformatf("req_ready[%0d]", d), 64'(obs_ready[d]), 64'(rq[d].size() < DEPTH));
            checkOutput($sformatf("rout_multi[%0d]", d), 64'($countones(obs_rout[d]) > 1), 64'd0);
        end
    endtask

    task automatic applyStimulus(input bit v, input int s, input int t, input bit f);
        req_valid = v;
        req_src   = 4'(s);
        req_dst   = 4'(t);
        flush     = f;
    endtask

    task automatic step();
        @(posedge clk);
        if (!resetn) model_reset();
        else         model_update();
        @(negedge clk);
        cycle++;
        check_all();
    endtask

    task automatic idle(input int n);
        applyStimulus(1'b0, 0, 0, 1'b0);
        repeat (n) step();
    endtask

    initial begin
        bit found;
        bit saw_full;
        int dc [NDUT][$];
        int diff;
        int exp_period [NDUT] = '{4, 3, 6};

        model_reset();
        applyStimulus(1'b0, 0, 0, 1'b0);
        #1 resetn = 1'b0;
        repeat (2) step();
        checkOutput("reset_rout", obs_rout[0], 64'd0);
        checkOutput("reset_ready", 64'(obs_ready[0]), 64'd1);
        resetn = 1'b1;
        idle(2);

        $display("[TB] single transfer src=3 dst=7");
        applyStimulus(1'b1, 3, 7, 1'b0);
        step();
        applyStimulus(1'b0, 0, 0, 1'b0);
        checkOutput("t1_pop_rout", obs_rout[0], 64'd0);
        step();
        checkOutput("t1_drive_rout", obs_rout[0], 64'h8);
        checkOutput("t1_drive_ren", obs_ren[0], 64'd0);
        step();
        checkOutput("t1_latch_rout", obs_rout[0], 64'h8);
        checkOutput("t1_latch_ren", obs_ren[0], 64'h80);
        checkOutput("t1_latch_done", 64'(obs_done[0]), 64'd1);
        step();
        checkOutput("t1_gap_rout", obs_rout[0], 64'd0);
        checkOutput("t1_gap_ren", obs_ren[0], 64'd0);
        idle(6);

        $display("[TB] back-to-back pushes into a depth-%0d queue", DEPTH);
        saw_full = 1'b0;
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b1, $urandom_range(0, 11), $urandom_range(0, 11), 1'b0);
            step();
            if (!obs_ready[0]) saw_full = 1'b1;
        end
        checkOutput("t2_full_seen", 64'(saw_full), 64'd1);
        idle(50);

        $display("[TB] out-of-range request followed by a valid one");
        applyStimulus(1'b1, 13, 2, 1'b0);
        step();
        applyStimulus(1'b1, 1, 2, 1'b0);
        step();
        applyStimulus(1'b0, 0, 0, 1'b0);
        checkOutput("t3_err", 64'(obs_err[1]), 64'd1);
        checkOutput("t3_err_rout", obs_rout[1], 64'd0);
        idle(15);

        $display("[TB] flush during LATCH");
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, $urandom_range(0, 11), $urandom_range(0, 11), 1'b0);
            step();
        end
        applyStimulus(1'b0, 0, 0, 1'b0);
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            if (obs_ren[0] != 64'd0) found = 1'b1;
            else step();
        end
        checkOutput("t4_latch_reached", 64'(found), 64'd1);
        applyStimulus(1'b0, 0, 0, 1'b1);
        step();
        applyStimulus(1'b0, 0, 0, 1'b0);
        for (int d = 0; d < NDUT; d++) begin
            checkOutput($sformatf("t4_rout[%0d]", d), obs_rout[d], 64'd0);
            checkOutput($sformatf("t4_busy[%0d]", d), 64'(obs_busy[d]), 64'd0);
            checkOutput($sformatf("t4_done[%0d]", d), 64'(obs_done[d]), 64'd0);
        end
        idle(4);

        $display("[TB] asynchronous reset during DRIVE");
        applyStimulus(1'b1, 5, 9, 1'b0);
        step();
        applyStimulus(1'b0, 0, 0, 1'b0);
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            if (obs_rout[0] != 64'd0 && obs_ren[0] == 64'd0) found = 1'b1;
            else step();
        end
        checkOutput("t5_drive_reached", 64'(found), 64'd1);
        #2 resetn = 1'b0;
        #1;
        model_reset();
        for (int d = 0; d < NDUT; d++) begin
            checkOutput($sformatf("t5_async_rout[%0d]", d), obs_rout[d], 64'd0);
            checkOutput($sformatf("t5_async_busy[%0d]", d), 64'(obs_busy[d]), 64'd0);
        end
        step();
        resetn = 1'b1;
        step();
        checkOutput("t5_ready_after", 64'(obs_ready[0]), 64'd1);
        idle(3);

        $display("[TB] transfer period versus gap length");
        applyStimulus(1'b1, 2, 4, 1'b0);
        step();
        applyStimulus(1'b1, 6, 8, 1'b0);
        step();
        applyStimulus(1'b0, 0, 0, 1'b0);
        for (int k = 0; k < 30; k++) begin
            for (int d = 0; d < NDUT; d++) begin
                if (obs_done[d]) dc[d].push_back(k);
            end
            step();
        end
        for (int d = 0; d < NDUT; d++) begin
            diff = (dc[d].size() >= 2) ? (dc[d][1] - dc[d][0]) : -1;
            checkOutput($sformatf("t6_period[%0d]", d), 64'(diff), 64'(exp_period[d]));
        end

        $display("[TB] randomized traffic");
        for (int i = 0; i < 400; i++) begin
            applyStimulus($urandom_range(0, 99) < 60, $urandom_range(0, 15),
                          $urandom_range(0, 15), $urandom_range(0, 99) < 3);
            step();
        end
        idle(60);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
